// File: rtl/sram_seq.sv
// sram_seq: Avalon-MM to async SRAM setup/strobe/hold sequencer; define SRAM_SEQ_TURNAROUND_EN for a TURN cycle after reads
module sram_seq #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [7:0]        avs_writedata,
    input  logic              avs_byteenable,
    output logic              avs_waitrequest,
    output logic [7:0]        avs_readdata,
    output logic              avs_readdatavalid,
    output logic              m_chipselect_n,
    output logic              m_byteenable_n,
    output logic              m_read_n,
    output logic              m_write_n,
    output logic [ADDR_W-1:0] m_address,
    output logic [7:0]        m_writedata,
    input  logic [7:0]        m_readdata
);
    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("sram_seq: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

`ifdef SRAM_SEQ_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
`endif

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       wr_q, be_q;
    logic       accept, active, done_rd;

    assign accept          = (state == IDLE) && (avs_read || avs_write);
    assign active          = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
    assign done_rd         = (state == STROBE) && (cnt == 4'd0) && !wr_q;
    assign avs_waitrequest = !reset_n || (state != IDLE);

    // next-state sequencing through setup, strobe, hold (and turnaround after reads)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == 4'd0) state_nxt = HOLD;
`ifdef SRAM_SEQ_TURNAROUND_EN
            HOLD:    state_nxt = wr_q ? IDLE : TURN;
            TURN:    state_nxt = IDLE;
`else
            HOLD:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // command latches, strobe counter and registered pin drive derived from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt               <= '0;
            wr_q              <= 1'b0;
            be_q              <= 1'b0;
            m_address         <= '0;
            m_writedata       <= '0;
            m_chipselect_n    <= 1'b1;
            m_byteenable_n    <= 1'b1;
            m_read_n          <= 1'b1;
            m_write_n         <= 1'b1;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            if (accept) begin
                wr_q        <= avs_write;
                be_q        <= avs_byteenable;
                m_address   <= avs_address;
                m_writedata <= avs_writedata;
            end
            cnt               <= (state == SETUP) ? CNT_INIT : cnt - 4'd1;
            m_chipselect_n    <= !active;
            m_byteenable_n    <= !active ? 1'b1 : accept ? ~avs_byteenable : ~be_q;
            m_read_n          <= !((state_nxt == STROBE) && !wr_q);
            m_write_n         <= !((state_nxt == STROBE) && wr_q);
            avs_readdatavalid <= done_rd;
            if (done_rd) avs_readdata <= m_readdata;
        end
    end
endmodule

// File: tb/tb_sram_seq.sv
// tb_sram_seq: directed checks of sram_seq with W=1 and W=3 instances; honours SRAM_SEQ_TURNAROUND_EN
module tb_sram_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [16:0] addr1, addr3, m_addr1, m_addr3;
    logic        rd1, wr1, be1, rd3, wr3, be3;
    logic [7:0]  wd1, wd3, m_wd1, m_wd3, rdata1, rdata3, m_rd1, m_rd3;
    logic        wait1, rdv1, cs1, ben1, rn1, wn1;
    logic        wait3, rdv3, cs3, ben3, rn3, wn3;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    // SRAM models: W=1 instance returns address-derived data, W=3 instance returns 0xC3 at 0x10
    assign m_rd1 = m_addr1[7:0] ^ 8'hA5;
    assign m_rd3 = (m_addr3 == 17'h00010) ? 8'hC3 : 8'h00;

    sram_seq #(.WAIT_CYCLES(1), .ADDR_W(17)) u1 (
        .clk(clk), .reset_n(reset_n), .avs_address(addr1), .avs_read(rd1), .avs_write(wr1),
        .avs_writedata(wd1), .avs_byteenable(be1), .avs_waitrequest(wait1), .avs_readdata(rdata1),
        .avs_readdatavalid(rdv1), .m_chipselect_n(cs1), .m_byteenable_n(ben1), .m_read_n(rn1),
        .m_write_n(wn1), .m_address(m_addr1), .m_writedata(m_wd1), .m_readdata(m_rd1)
    );

    sram_seq #(.WAIT_CYCLES(3), .ADDR_W(17)) u3 (
        .clk(clk), .reset_n(reset_n), .avs_address(addr3), .avs_read(rd3), .avs_write(wr3),
        .avs_writedata(wd3), .avs_byteenable(be3), .avs_waitrequest(wait3), .avs_readdata(rdata3),
        .avs_readdatavalid(rdv3), .m_chipselect_n(cs3), .m_byteenable_n(ben3), .m_read_n(rn3),
        .m_write_n(wn3), .m_address(m_addr3), .m_writedata(m_wd3), .m_readdata(m_rd3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        {rd1, wr1, be1, rd3, wr3, be3} = '0;
        addr1 = '0; addr3 = '0; wd1 = '0; wd3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {cs1, ben1, rn1, wn1, cs3, ben3, rn3, wn3}, 8'hFF);
        chk("rst_rdv", {rdv1, rdv3}, 2'b00);
        chk("rst_wait", {wait1, wait3}, 2'b11);
        chk("rst_addr", m_addr1, 17'h0);
        chk("rst_rdata", rdata3, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_wait", {wait1, wait3}, 2'b00);

        // write W=1: cs low cycles 1..3, write strobe only cycle 2
        tick();
        addr1 = 17'h1ABCD; wd1 = 8'h5A; be1 = 1'b1; wr1 = 1'b1;
        tick();
        wr1 = 1'b0;
        chk("wr_c1_pins", {cs1, ben1, rn1, wn1}, 4'b0011);
        chk("wr_c1_wait", wait1, 1'b1);
        tick();
        chk("wr_c2_pins", {cs1, ben1, rn1, wn1}, 4'b0010);
        chk("wr_c2_addr", m_addr1, 17'h1ABCD);
        chk("wr_c2_data", m_wd1, 8'h5A);
        tick();
        chk("wr_c3_pins", {cs1, ben1, rn1, wn1}, 4'b0011);
        chk("wr_c3_rdv", rdv1, 1'b0);
        tick();
        chk("wr_c4_pins", {cs1, ben1, rn1, wn1}, 4'b1111);
        chk("wr_c4_wait", wait1, 1'b0);
        chk("wr_c4_hold_addr", {m_addr1, m_wd1}, {17'h1ABCD, 8'h5A});

        // read W=3 at 0x10: read strobe cycles 2..4, rdv with 0xC3 in cycle 5
        addr3 = 17'h00010; rd3 = 1'b1;
        tick();
        rd3 = 1'b0;
        chk("rd_c1_rn", rn3, 1'b1);
        tick();
        chk("rd_c2_rn", {cs3, rn3}, 2'b00);
        tick();
        chk("rd_c3_rn", {rn3, rdv3}, 2'b00);
        tick();
        chk("rd_c4_rn", {rn3, rdv3}, 2'b00);
        tick();
        chk("rd_c5_pins", {cs3, rn3, wn3}, 3'b011);
        chk("rd_c5_rdv", rdv3, 1'b1);
        chk("rd_c5_data", rdata3, 8'hC3);
        tick();
        chk("rd_c6_rdv", rdv3, 1'b0);
        chk("rd_c6_cs", cs3, 1'b1);
`ifdef SRAM_SEQ_TURNAROUND_EN
        chk("rd_c6_wait_turn", wait3, 1'b1);
        tick();
`endif
        chk("rd_idle_wait", wait3, 1'b0);
        chk("rd_data_held", rdata3, 8'hC3);

        // simultaneous read and write: treated as write, no rdv
        addr1 = 17'h00022; wd1 = 8'h11; rd1 = 1'b1; wr1 = 1'b1;
        tick();
        rd1 = 1'b0; wr1 = 1'b0;
        tick();
        chk("rw_c2_strobes", {rn1, wn1}, 2'b10);
        chk("rw_c2_data", m_wd1, 8'h11);
        tick();
        chk("rw_c3_rdv", rdv1, 1'b0);
        tick();
        chk("rw_c4_rdv", rdv1, 1'b0);
        chk("rw_c4_wait", wait1, 1'b0);

        // write with byteenable low runs the full sequence with byteenable_n high
        addr1 = 17'h00050; wd1 = 8'hE7; be1 = 1'b0; wr1 = 1'b1;
        tick();
        wr1 = 1'b0;
        tick();
        chk("be0_c2_pins", {cs1, ben1, wn1}, 3'b010);
        repeat (2) tick();
        chk("be0_done", wait1, 1'b0);

        // read then write held back-to-back, W=1
        be1 = 1'b1; addr1 = 17'h00033; rd1 = 1'b1;
        tick();
        rd1 = 1'b0; wr1 = 1'b1; addr1 = 17'h00044; wd1 = 8'h77;
        n = 1;
        while (wait1 && n < 8) begin
            tick();
            n++;
            if (n == 3) begin
                chk("b2b_rdv", rdv1, 1'b1);
                chk("b2b_rdata", rdata1, 8'h96);
            end
        end
`ifdef SRAM_SEQ_TURNAROUND_EN
        chk("b2b_accept_cycle", n, 5);
`else
        chk("b2b_accept_cycle", n, 4);
`endif
        tick();
        wr1 = 1'b0;
        chk("b2b_wr_setup", {cs1, rn1, wn1}, 3'b011);
        chk("b2b_wr_addr", {m_addr1, m_wd1}, {17'h00044, 8'h77});
        repeat (3) tick();
        chk("b2b_idle", wait1, 1'b0);

        // reset during read strobe on W=3
        addr3 = 17'h00010; rd3 = 1'b1;
        tick();
        rd3 = 1'b0;
        tick();
        chk("ab_strobe", {cs3, rn3}, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ab_async_pins", {cs3, rn3, ben3}, 3'b111);
        chk("ab_wait", wait3, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ab_no_rdv", rdv3, 1'b0);
        end
        chk("ab_rdata_cleared", rdata3, 8'h00);
        rd3 = 1'b1;
        tick();
        rd3 = 1'b0;
        repeat (4) tick();
        chk("ab_next_rdv", {rdv3, rdata3}, {1'b1, 8'hC3});
        repeat (3) tick();
        chk("ab_next_idle", wait3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_seq.md
# sram_seq

Avalon-MM slave sequencer that turns single-cycle bus reads and writes into timed setup/strobe/hold cycles for the 8-bit asynchronous SRAM pin wrapper. It sits directly upstream of the SRAM wrapper: it drives that wrapper's active-low chipselect, byteenable, read and write strobes, address and write data, and it captures the returned read data. One access is in flight at a time. Read data returns through a readdatavalid pulse.

## Interface
Parameters:
- WAIT_CYCLES, 1: number of cycles the read or write strobe is held low. Legal range is 1..15; any other value is an elaboration error.
- ADDR_W, 17: address width.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  ADDR_W  byte address.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  8  write data.
- avs_byteenable  in  1  byte enable, active high.
- avs_waitrequest  out  1  high while the block cannot accept a command.
- avs_readdata  out  8  registered read data.
- avs_readdatavalid  out  1  one-cycle pulse marking valid avs_readdata.
- m_chipselect_n  out  1  to the wrapper's chip select.
- m_byteenable_n  out  1  to the wrapper's byte enable.
- m_read_n  out  1  to the wrapper's read strobe.
- m_write_n  out  1  to the wrapper's write strobe.
- m_address  out  ADDR_W  to the wrapper's address.
- m_writedata  out  8  to the wrapper's write data.
- m_readdata  in  8  from the wrapper's read data.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN. TURN exists only with the configuration macro.
- avs_waitrequest = !reset_n || (state != IDLE).
- Acceptance:
  - A command is accepted at a clock edge where state is IDLE and avs_read or avs_write is high.
  - On acceptance, latch address, writedata, byteenable and direction, then go to SETUP.
  - If avs_read and avs_write are both high, the command is a write. The read is consumed and produces no readdatavalid.
- SETUP (1 cycle):
  - m_chipselect_n=0 and m_byteenable_n=~be_latched.
  - Address and data are driven from the latches.
  - Both strobes stay high.
- STROBE (WAIT_CYCLES cycles):
  - m_read_n=0 for a read, or m_write_n=0 for a write. All other outputs hold.
  - A 4-bit counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle. The block exits when the counter is 0.
- HOLD (1 cycle):
  - Both strobes are high. chipselect, byteenable, address and writedata are held.
  - For a read, avs_readdata is loaded from m_readdata at the edge leaving STROBE, and avs_readdatavalid=1 during HOLD.
- After HOLD the block goes to IDLE. With the macro, it goes to TURN after a read, then to IDLE.
- In IDLE and TURN: m_chipselect_n=1, m_byteenable_n=1, and both strobes are 1. m_address and m_writedata keep their last values.
- A write with avs_byteenable=0 runs the full sequence with m_byteenable_n=1.
- avs_readdata holds its value until the next read completes.

## Timing
- All outputs are registered except avs_waitrequest.
- Reset values:
  - State IDLE.
  - All m_*_n outputs = 1.
  - m_address=0, m_writedata=0.
  - avs_readdata=0, avs_readdatavalid=0.
  - avs_waitrequest=1 while reset_n is low.
- Cycle numbering, with the accepting edge E0:
  - SETUP is cycle 1.
  - STROBE is cycles 2..1+W.
  - HOLD is cycle 2+W, with readdatavalid high in that cycle.
  - IDLE is cycle 3+W.
- Occupancy is W+3 cycles per access, plus 1 after a read when the macro is defined.
- Reset mid-access:
  - All strobes and chipselect go high asynchronously.
  - State returns to IDLE.
  - No readdatavalid is produced for the aborted read.
- Back-to-back commands: a request held high through waitrequest is accepted on the first edge at which the block is in IDLE.

## Configuration
- SRAM_SEQ_TURNAROUND_EN defined: every read is followed by one TURN cycle. In TURN, chipselect and the strobes are high and waitrequest is high. This gives the SRAM data-bus release time before a following write.
- Not defined: HOLD goes directly to IDLE for both directions. There is no TURN state.

## Test plan
- Reset: hold reset_n=0 -> all m_*_n outputs =1, avs_readdatavalid=0, avs_waitrequest=1. Release -> avs_waitrequest=0.
- Write, W=1, address 0x1ABCD, data 0x5A, be=1:
  - m_chipselect_n low for cycles 1..3 and m_write_n low only in cycle 2.
  - m_address=0x1ABCD and m_writedata=0x5A throughout.
  - waitrequest low again in cycle 4.
- Read, W=3, with the model returning 0xC3 at address 0x00010:
  - m_read_n low in cycles 2..4.
  - avs_readdatavalid high only in cycle 5 with avs_readdata=0xC3.
- Simultaneous read and write high, data 0x11:
  - A write strobe is issued and no read strobe.
  - No readdatavalid pulse.
- Read then write held back-to-back, W=1:
  - Write accepted at cycle 4 without the macro, or at cycle 5 with SRAM_SEQ_TURNAROUND_EN.
- Assert reset_n low during STROBE of a read:
  - m_read_n and m_chipselect_n go high immediately.
  - No readdatavalid follows.
  - The next command is accepted normally.
